// File: rtl/iter_divider_pkg.sv
// Shared types and widths for the iterative divider.
// Imported by the divider top and its helpers.
package iter_divider_pkg;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;
endpackage

// File: rtl/neg_abs.sv
// Conditional two's-complement negate.
// Used for operand magnitude and result sign restore.
module neg_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] in,
   input  logic         neg_en,
   output logic [W-1:0] out
);
   assign out = neg_en ? (W'(0) - in) : in;
endmodule

// File: rtl/iter_divider.sv
// Restoring DIV/DIVU unit, one quotient bit per clock.
// LO takes the quotient, HI the remainder.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state, nstate;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] q, rem, dvs;
   logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
   logic [WIDTH:0] sh, diff;
   logic a_neg, b_neg;
   logic qneg, rneg, dz;

   assign a_neg = sign_mode & dividend[WIDTH-1];
   assign b_neg = sign_mode & divisor[WIDTH-1];

   neg_abs #(.W(WIDTH)) u_abs_a (
      .in(dividend), .neg_en(a_neg), .out(a_abs)
   );
   neg_abs #(.W(WIDTH)) u_abs_b (
      .in(divisor), .neg_en(b_neg), .out(b_abs)
   );
   neg_abs #(.W(WIDTH)) u_fix_q (
      .in(q), .neg_en(qneg), .out(q_fix)
   );
   neg_abs #(.W(WIDTH)) u_fix_r (
      .in(rem), .neg_en(rneg), .out(r_fix)
   );

   // Extra top bit keeps the borrow when rem has its MSB set
   assign sh   = {rem, q[WIDTH-1]};
   assign diff = sh - {1'b0, dvs};

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE: if (start) nstate = S_CALC;
         S_CALC: if (cnt == LAST) nstate = S_FIX;
         S_FIX:  nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         q           <= '0;
         rem         <= '0;
         dvs         <= '0;
         qneg        <= 1'b0;
         rneg        <= 1'b0;
         dz          <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  q    <= a_abs;
                  dvs  <= b_abs;
                  rem  <= '0;
                  cnt  <= '0;
                  qneg <= a_neg ^ b_neg;
                  rneg <= a_neg;
                  dz   <= (divisor == '0);
               end
            end
            S_CALC: begin
               cnt <= cnt + CW'(1);
               q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
               rem <= diff[WIDTH] ? sh[WIDTH-1:0]
                                  : diff[WIDTH-1:0];
            end
            S_FIX: begin
               // A zero divisor leaves rem = |dividend|, so r_fix
               // restores the original dividend; only q is overridden.
               quotient    <= dz ? '1 : q_fix;
               remainder   <= r_fix;
               div_by_zero <= dz;
               done        <= 1'b1;
               cnt         <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider.
// Directed DIV/DIVU vectors, latency, abort and back-to-back cases.
module tb_iter_divider;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic sign_mode = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int checks = 0;
   int failures = 0;
   logic [31:0] eq_q[$];
   logic [31:0] er_q[$];
   logic [31:0] edz_q[$];
   logic prev_done = 1'b0;
   int nb, di;

   always #5 clk = ~clk;

   iter_divider #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .sign_mode(sign_mode),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (done) begin
            chk("done_single_pulse", {31'b0, prev_done}, 32'd0);
            if (eq_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               chk("quotient", quotient, eq_q.pop_front());
               chk("remainder", remainder, er_q.pop_front());
               chk("div_by_zero", {31'b0, div_by_zero},
                   edz_q.pop_front());
            end
         end
         prev_done = done;
      end
   end

   // Called at a negedge; returns 1ns after the accepting edge.
   task automatic issue(input logic sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout busy=1 required=0");
      end
      start = 1'b1;
      sign_mode = sm;
      dividend = a;
      divisor = b;
      @(posedge clk);
      #1 start = 1'b0;
      eq_q.push_back(eq);
      er_q.push_back(er);
      edz_q.push_back({31'b0, edz});
   endtask

   // Cycle 1 is the negedge right after the accepting edge.
   task automatic measure(input int inj, output int nbusy,
                          output int dcyc);
      nbusy = 0;
      dcyc = 0;
      for (int i = 1; i <= 60 && dcyc == 0; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) dcyc = i;
         if (i == inj) begin
            start = 1'b1;
            dividend = 32'd9;
            divisor = 32'd9;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (eq_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drain", eq_q.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      measure(0, nb, di);
      chk("busy_cycles", nb, 32'd33);
      chk("done_cycle", di, 32'd34);

      issue(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0);
      measure(5, nb, di);
      chk("b2b_busy_cycles", nb, 32'd33);
      chk("b2b_done_cycle", di, 32'd34);

      issue(1'b1, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      issue(1'b1, 32'd7, 32'hFFFFFFFE,
            32'hFFFFFFFD, 32'd1, 1'b0);
      issue(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
            32'd14, 32'hFFFFFFFE, 1'b0);
      issue(1'b1, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 32'd0, 1'b0);
      issue(1'b0, 32'h80000000, 32'hFFFFFFFF,
            32'd0, 32'h80000000, 1'b0);
      issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE,
            32'd1, 32'd1, 1'b0);
      issue(1'b0, 32'hFFFFFFFF, 32'd1,
            32'hFFFFFFFF, 32'd0, 1'b0);
      issue(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
      issue(1'b1, 32'hFFFFFFFB, 32'd0,
            32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
      drain();

      start = 1'b1;
      sign_mode = 1'b0;
      dividend = 32'd100;
      divisor = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      chk("abort_dz", {31'b0, div_by_zero}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      issue(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
